// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the FPGA datapaths, plus the constants
// used by the exponential block.
package fpga_cfg_pkg;

    localparam int  FP_WIDTH     = 32;
    localparam int  FP_QINT      = 15;
    localparam int  FP_QFRAC     = 16;
    localparam int  EXP_LUT_BITS = 12;
    localparam real LOG2E        = 1.4426950408889634;

    // round(log2(e) * 2^qfrac), sized to the fractional width in use
    function automatic longint log2e_q(input int qfrac);
        return longint'(LOG2E * (2.0 ** qfrac));
    endfunction

    // round(2^(i / 2^lut_bits) * 2^qfrac): one ROM entry, value in [1,2)
    function automatic longint exp2_entry(input int i, input int lut_bits, input int qfrac);
        return longint'((2.0 ** (real'(i) / (2.0 ** lut_bits))) * (2.0 ** qfrac));
    endfunction

endpackage

// File: rtl/fx_exp2_rom.sv
// Registered 2^f block ROM; contents are generated at elaboration so the
// table always matches the configured LUT_BITS / QFRAC.
module fx_exp2_rom
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH    = FP_WIDTH,
    parameter int QFRAC    = FP_QFRAC,
    parameter int LUT_BITS = EXP_LUT_BITS
) (
    input  logic                clk,
    input  logic                en,
    input  logic [LUT_BITS-1:0] addr,
    output logic [WIDTH-1:0]    data
);

    localparam int DEPTH = 2 ** LUT_BITS;

    (* rom_style = "block" *) logic [WIDTH-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam longint ENTRY = exp2_entry(i, LUT_BITS, QFRAC);
        assign rom[i] = WIDTH'(ENTRY);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/fx_exp_lut.sv
// Fixed-point e^x: x*log2(e) = k + f, 2^f from ROM, then shifted by k with
// saturation. Three-stage pipeline, one result per cycle, valid/ready both sides.
module fx_exp_lut
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH    = FP_WIDTH,
    parameter int QINT     = FP_QINT,
    parameter int QFRAC    = FP_QFRAC,
    parameter int LUT_BITS = EXP_LUT_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       sat
);

    localparam int PW  = 2 * WIDTH;
    localparam int SHW = $clog2(QINT + QFRAC + 1);
    localparam logic signed [PW-1:0] LOG2E_Q = PW'(log2e_q(QFRAC));

    if (QFRAC < LUT_BITS) begin : g_cfg_check
        $error("fx_exp_lut: QFRAC must be >= LUT_BITS");
    end

    logic                    en;
    logic                    v1, v2, v3;
    logic signed [PW-1:0]    prod;
    logic signed [WIDTH-1:0] k1;
    logic [LUT_BITS-1:0]     idx1;
    logic                    ovf2, unf2, left2;
    logic [SHW-1:0]          amt2;
    logic [WIDTH-1:0]        lut2;

    assign en        = !v3 || ready_in;
    assign ready_out = en;
    assign valid_out = v3;
    assign prod      = $signed({{WIDTH{a[WIDTH-1]}}, a}) * LOG2E_Q;

    fx_exp2_rom #(
        .WIDTH   (WIDTH),
        .QFRAC   (QFRAC),
        .LUT_BITS(LUT_BITS)
    ) u_rom (
        .clk (clk),
        .en  (en),
        .addr(idx1),
        .data(lut2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            k1     <= '0;
            idx1   <= '0;
            ovf2   <= 1'b0;
            unf2   <= 1'b0;
            left2  <= 1'b0;
            amt2   <= '0;
            result <= '0;
            sat    <= '0;
        end else if (en) begin
            v1 <= valid_in;
            v2 <= v1;
            v3 <= v2;

            // p = prod >>> QFRAC is never stored: k and the ROM index (top
            // LUT_BITS of f) are sliced straight out of the double-width product.
            k1   <= WIDTH'(prod >>> (2 * QFRAC));
            idx1 <= LUT_BITS'(prod >>> (2 * QFRAC - LUT_BITS));

            ovf2  <= k1 >= QINT;
            unf2  <= k1 < -QFRAC;
            left2 <= !k1[WIDTH-1];
            amt2  <= k1[WIDTH-1] ? SHW'(-k1) : SHW'(k1);

            if (ovf2) begin
                result <= {1'b0, {(WIDTH-1){1'b1}}};
                sat    <= 2'b10;
            end else if (unf2) begin
                result <= '0;
                sat    <= 2'b01;
            end else if (left2) begin
                result <= lut2 << amt2;
                sat    <= 2'b00;
            end else begin
                result <= lut2 >> amt2;
                sat    <= 2'b00;
            end
        end
    end

    hold_while_stalled: assert property (@(posedge clk) disable iff (!rst_n)
        valid_out && !ready_in |=> $stable(result) && $stable(sat));

endmodule

// File: tb/tb_fx_exp_lut.sv
// Bench for fx_exp_lut: real-valued e^x reference with tolerance, directed
// cases with literal expectations, back-pressure, mid-flight reset, random sweep.
module tb_fx_exp_lut;

    localparam int  WIDTH    = 32;
    localparam int  QINT     = 15;
    localparam int  QFRAC    = 16;
    localparam int  LUT_BITS = 12;
    localparam real SCALE    = 65536.0;
    localparam real LOG2E_R  = 1.4426950408889634;
    localparam real LN2      = 0.6931471805599453;
    localparam real MARGIN   = 1.0e-3;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             valid_in = 1'b0;
    logic             ready_in = 1'b1;
    logic [WIDTH-1:0] a        = '0;
    logic             ready_out;
    logic             valid_out;
    logic [WIDTH-1:0] result;
    logic [1:0]       sat;

    always #5 clk = ~clk;

    fx_exp_lut #(
        .WIDTH   (WIDTH),
        .QINT    (QINT),
        .QFRAC   (QFRAC),
        .LUT_BITS(LUT_BITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .a        (a),
        .valid_out(valid_out),
        .ready_in (ready_in),
        .result   (result),
        .sat      (sat)
    );

    typedef struct {
        logic [31:0] a;
        int          cyc;
        int          stalls;
        bit          lit_en;
        logic [31:0] lit_val;
        int          lit_tol;
        logic [1:0]  lit_sat;
    } txn_t;

    txn_t        exp_q[$];
    int          n_tests = 0, n_fail = 0;
    int          n_in = 0, n_out = 0, n_flushed = 0;
    int          cyc = 0, stall_cnt = 0;
    int          rmode = 0;  // 0: ready, 1: held low, 2: random
    bit          lit_en = 1'b0;
    logic [31:0] lit_val = '0;
    int          lit_tol = 0;
    logic [1:0]  lit_sat = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_result = '0;
    logic [1:0]  prev_sat = '0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Real-valued reference: e^x in LSBs, saturating outside [2^-16, 2^15);
    // decisions within MARGIN of a saturation boundary may go either way.
    function automatic bit model_ok(input logic [31:0] av, input logic [31:0] r,
                                    input logic [1:0] s, output logic [31:0] nominal);
        real x, e2, y, tol, diff, ax;
        bit  near_ovf, near_unf;
        x  = real'($signed(av)) / SCALE;
        e2 = x * LOG2E_R;
        near_ovf = (e2 > 15.0 - MARGIN) && (e2 < 15.0 + MARGIN);
        near_unf = (e2 > -16.0 - MARGIN) && (e2 < -16.0 + MARGIN);
        if (e2 >= 15.0)       nominal = 32'h7FFF_FFFF;
        else if (e2 < -16.0)  nominal = '0;
        else                  nominal = 32'(longint'($exp(x) * SCALE));
        if (s == 2'b10) return (e2 >= 15.0 || near_ovf) && r == 32'h7FFF_FFFF;
        if (s == 2'b01) return (e2 < -16.0 || near_unf) && r == '0;
        if (s != 2'b00) return 1'b0;
        if (e2 >= 15.0 && !near_ovf) return 1'b0;
        if (e2 < -16.0 && !near_unf) return 1'b0;
        ax   = (x < 0.0) ? -x : x;
        y    = $exp(x) * SCALE;
        // LUT step error, plus quantisation of log2(e) and of x*log2(e), plus shift truncation
        tol  = y * ((2.0 ** (-LUT_BITS)) * LN2 + (ax + 2.0) / SCALE) + 2.0;
        diff = real'(r) - y;
        if (diff < 0.0) diff = -diff;
        return diff <= tol;
    endfunction

    function automatic int spec_tol(input logic [31:0] v);
        return int'(real'(v) * (2.0 ** (-LUT_BITS)) * LN2) + 2;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       ready_in = 1'b1;
            1:       ready_in = 1'b0;
            default: ready_in = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Compare process: accepts feed the model queue, every delivered result is checked.
    always @(negedge clk) begin
        txn_t        t;
        logic [31:0] nom;
        int          d;
        bit          ok;
        cyc++;
        if (rst_n) begin
            if (prev_stall)
                check(valid_out && result == prev_result && sat == prev_sat,
                      "stall_hold", result, prev_result);
            if (valid_out && !ready_in) begin
                stall_cnt++;
                check(!ready_out, "stall_ready_out", 32'(ready_out), 32'd0);
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", result, 32'd0);
                end else begin
                    t = exp_q.pop_front();
                    n_out++;
                    ok = model_ok(t.a, result, sat, nom);
                    check(ok, $sformatf("model a=0x%08h sat=%b", t.a, sat), result, nom);
                    if (t.stalls == stall_cnt)
                        check(cyc - t.cyc == 3, "latency", 32'(cyc - t.cyc), 32'd3);
                    if (t.lit_en) begin
                        d = int'(result) - int'(t.lit_val);
                        if (d < 0) d = -d;
                        check(sat == t.lit_sat && d <= t.lit_tol,
                              $sformatf("literal a=0x%08h sat=%b/%b", t.a, sat, t.lit_sat),
                              result, t.lit_val);
                    end
                end
            end
            if (valid_in && ready_out) begin
                t.a       = a;
                t.cyc     = cyc;
                t.stalls  = stall_cnt;
                t.lit_en  = lit_en;
                t.lit_val = lit_val;
                t.lit_tol = lit_tol;
                t.lit_sat = lit_sat;
                exp_q.push_back(t);
                n_in++;
            end
            prev_stall  = valid_out && !ready_in;
            prev_result = result;
            prev_sat    = sat;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the operand was accepted.
    task automatic send(input logic [31:0] av, input bit le, input logic [31:0] lv,
                        input int lt, input logic [1:0] ls);
        int waited = 0;
        a        = av;
        valid_in = 1'b1;
        lit_en   = le;
        lit_val  = lv;
        lit_tol  = lt;
        lit_sat  = ls;
        @(negedge clk);
        while (!ready_out && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_out) check(1'b0, "accept_timeout", 32'(ready_out), 32'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        lit_en   = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got %0d outputs, expected %0d", n_out, n_in - n_flushed);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          v;
        int          st0;
        logic [31:0] av;

        repeat (3) @(posedge clk);
        #2;
        check(valid_out == 1'b0, "rst_valid_out", 32'(valid_out), 32'd0);
        check(ready_out == 1'b1, "rst_ready_out", 32'(ready_out), 32'd1);
        check(result == '0, "rst_result", result, 32'd0);
        check(sat == 2'b00, "rst_sat", 32'(sat), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'h0000_0000, 1'b1, 32'h0001_0000, 0, 2'b00);
        drain();

        send(32'h0001_0000, 1'b1, 32'h0002_B7E1, spec_tol(32'h0002_B7E1), 2'b00);
        send(32'hFFFF_0000, 1'b1, 32'h0000_5E2D, spec_tol(32'h0000_5E2D), 2'b00);
        send(32'h0000_B172, 1'b1, 32'h0002_0000, spec_tol(32'h0002_0000), 2'b00);
        send(32'h000B_0000, 1'b1, 32'h7FFF_FFFF, 0, 2'b10);
        send(32'hFFF4_0000, 1'b1, 32'h0000_0000, 0, 2'b01);
        drain();

        // Back-pressure: three operands fill the pipe, a fourth is held off
        rmode = 1;
        @(posedge clk);
        #1;
        st0 = stall_cnt;
        send(32'h0002_0000, 1'b0, '0, 0, 2'b00);
        send(32'hFFFE_0000, 1'b0, '0, 0, 2'b00);
        send(32'h0000_8000, 1'b0, '0, 0, 2'b00);
        fork
            begin
                repeat (6) @(posedge clk);
                rmode = 0;
            end
        join_none
        send(32'h0003_0000, 1'b0, '0, 0, 2'b00);
        drain();
        check(stall_cnt - st0 >= 5, "bp_stall_cycles", 32'(stall_cnt - st0), 32'd5);

        // Reset with two operands still in flight
        send(32'h0001_0000, 1'b0, '0, 0, 2'b00);
        send(32'h0002_0000, 1'b0, '0, 0, 2'b00);
        send(32'hFFFF_0000, 1'b0, '0, 0, 2'b00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check(valid_out == 1'b0, "midrst_valid_out", 32'(valid_out), 32'd0);
        check(ready_out == 1'b1, "midrst_ready_out", 32'(ready_out), 32'd1);
        check(exp_q.size() == 2, "midrst_in_flight", 32'(exp_q.size()), 32'd2);
        n_flushed += exp_q.size();
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h0000_0000, 1'b1, 32'h0001_0000, 0, 2'b00);
        drain();

        // Random sweep with random ready_in and input gaps
        rmode = 2;
        for (int unsigned i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 9))
                0:       av = $urandom();
                1:       begin v = 681386 + int'($urandom_range(0, 8192)) - 4096;  av = v; end
                2:       begin v = -726813 + int'($urandom_range(0, 8192)) - 4096; av = v; end
                default: begin v = int'($urandom_range(0, 23 * 65536)) - 12 * 65536; av = v; end
            endcase
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            send(av, 1'b0, '0, 0, 2'b00);
        end
        rmode = 0;
        drain();
        check(n_in == n_out + n_flushed, "count_in_out", 32'(n_out + n_flushed), 32'(n_in));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
